// File: rtl/lpm_tbl_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lpm_tbl_arbiter                                           |
// | Brief    : round-robin arbiter giving two requesters one-at-a-time    |
// |            access to the LPM table, with ack timeout; optional table  |
// |            clear engine compiled in by LPM_TBL_ARB_CLEAR_EN.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module lpm_tbl_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int ACK_TIMEOUT        = 15
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic                              req0_valid,
  input  logic                              req0_wr,
  input  logic [4:0]                        req0_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   req0_wdata,
  output logic                              req0_ready,
  input  logic                              req1_valid,
  input  logic                              req1_wr,
  input  logic [4:0]                        req1_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   req1_wdata,
  output logic                              req1_ready,
  output logic                              rsp_valid,
  output logic                              rsp_id,
  output logic                              rsp_err,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                              tbl_rd_req,
  output logic                              tbl_wr_req,
  output logic [4:0]                        tbl_rd_addr,
  output logic [4:0]                        tbl_wr_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
  input  logic                              tbl_rd_ack,
  input  logic                              tbl_wr_ack,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data,
  output logic [15:0]                       timeout_cnt,
  input  logic                              clr_start,
  output logic                              clr_busy
);

  localparam int          c_ent_w    = 4 * C_S_AXI_DATA_WIDTH;
  localparam int          c_cnt_w    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0]  c_st_idle  = 2'd0;
  localparam logic [1:0]  c_st_issue = 2'd1;
  localparam logic [1:0]  c_st_wait  = 2'd2;
  localparam logic [1:0]  c_st_resp  = 2'd3;
  localparam logic [15:0] c_tmo_max  = 16'hFFFF;

  logic [1:0]         r_state;
  logic               r_last;
  logic               r_id;
  logic               r_wr;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_req0_ready, r_req1_ready;
  logic               r_rsp_valid, r_rsp_id, r_rsp_err;
  logic [c_ent_w-1:0] r_rsp_rdata;
  logic               r_tbl_rd_req, r_tbl_wr_req;
  logic [4:0]         r_tbl_rd_addr, r_tbl_wr_addr;
  logic [c_ent_w-1:0] r_tbl_wr_data;
  logic [15:0]        r_timeout_cnt;
  logic               r_clr_busy;

  logic               w_any_valid, w_grant_id, w_sel_wr, w_ack, w_expire, w_err;
  logic [4:0]         w_sel_addr;
  logic [c_ent_w-1:0] w_sel_wdata;

  // Contention goes to whichever requester was not served last.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_grant_id  = req1_valid;
    if (req0_valid && req1_valid) w_grant_id = ~r_last;
    w_sel_wr    = w_grant_id ? req1_wr    : req0_wr;
    w_sel_addr  = w_grant_id ? req1_addr  : req0_addr;
    w_sel_wdata = w_grant_id ? req1_wdata : req0_wdata;
    w_ack       = r_wr ? tbl_wr_ack : tbl_rd_ack;
    w_expire    = (r_wait_cnt == c_cnt_w'(ACK_TIMEOUT - 1));
    w_err       = ~w_ack;
  end

`ifdef LPM_TBL_ARB_CLEAR_EN
  logic [4:0] r_clr_idx;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_start;
`endif

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_state       <= c_st_idle;
      r_last        <= 1'b1;
      r_id          <= 1'b0;
      r_wr          <= 1'b0;
      r_wait_cnt    <= '0;
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_rdata   <= '0;
      r_tbl_rd_req  <= 1'b0;
      r_tbl_wr_req  <= 1'b0;
      r_tbl_rd_addr <= '0;
      r_tbl_wr_addr <= '0;
      r_tbl_wr_data <= '0;
      r_timeout_cnt <= '0;
      r_clr_busy    <= 1'b0;
`ifdef LPM_TBL_ARB_CLEAR_EN
      r_clr_idx     <= '0;
`endif
    end else begin
      r_req0_ready <= 1'b0;
      r_req1_ready <= 1'b0;
      r_tbl_rd_req <= 1'b0;
      r_tbl_wr_req <= 1'b0;
      case (r_state)
        c_st_idle: begin
`ifdef LPM_TBL_ARB_CLEAR_EN
          if (clr_start && !r_clr_busy) begin
            r_clr_busy    <= 1'b1;
            r_clr_idx     <= '0;
            r_wr          <= 1'b1;
            r_tbl_wr_req  <= 1'b1;
            r_tbl_wr_addr <= '0;
            r_tbl_wr_data <= '1;
            r_wait_cnt    <= '0;
            r_state       <= c_st_issue;
          end else
`endif
          if (w_any_valid && !r_clr_busy) begin
            r_req0_ready <= ~w_grant_id;
            r_req1_ready <= w_grant_id;
            r_id         <= w_grant_id;
            r_last       <= w_grant_id;
            r_wr         <= w_sel_wr;
            r_wait_cnt   <= '0;
            if (w_sel_wr) begin
              r_tbl_wr_req  <= 1'b1;
              r_tbl_wr_addr <= w_sel_addr;
              r_tbl_wr_data <= w_sel_wdata;
            end else begin
              r_tbl_rd_req  <= 1'b1;
              r_tbl_rd_addr <= w_sel_addr;
            end
            r_state <= c_st_issue;
          end
        end
        c_st_issue: r_state <= c_st_wait;
        c_st_wait: begin
          // An ack landing on the expiry cycle still counts as success.
          if (w_ack || w_expire) begin
            if (w_err && (r_timeout_cnt != c_tmo_max))
              r_timeout_cnt <= r_timeout_cnt + 16'd1;
`ifdef LPM_TBL_ARB_CLEAR_EN
            if (r_clr_busy) begin
              if (r_clr_idx == 5'd31) begin
                r_clr_busy <= 1'b0;
                r_state    <= c_st_idle;
              end else begin
                r_clr_idx     <= r_clr_idx + 5'd1;
                r_tbl_wr_req  <= 1'b1;
                r_tbl_wr_addr <= r_clr_idx + 5'd1;
                r_wait_cnt    <= '0;
                r_state       <= c_st_issue;
              end
            end else
`endif
            begin
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= r_id;
              r_rsp_err   <= w_err;
              r_rsp_rdata <= (!w_err && !r_wr) ? tbl_rd_data : '0;
              r_state     <= c_st_resp;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        c_st_resp: begin
          r_rsp_valid <= 1'b0;
          r_rsp_id    <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_state     <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign req0_ready  = r_req0_ready;
  assign req1_ready  = r_req1_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_err     = r_rsp_err;
  assign rsp_rdata   = r_rsp_rdata;
  assign tbl_rd_req  = r_tbl_rd_req;
  assign tbl_wr_req  = r_tbl_wr_req;
  assign tbl_rd_addr = r_tbl_rd_addr;
  assign tbl_wr_addr = r_tbl_wr_addr;
  assign tbl_wr_data = r_tbl_wr_data;
  assign timeout_cnt = r_timeout_cnt;
  assign clr_busy    = r_clr_busy;

endmodule
`default_nettype wire
